// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, burst geometry and write-burst state encoding for the byte store.
package mem_pkg;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;
   localparam int BYTE_W = 8;
   localparam int CNT_W = 8;
   localparam int BYTES_PER_WORD = 4;
   localparam int DEPTH = 2 ** ADDR_W;
   typedef enum logic [1:0] {IDLE, WR1, WR2, WR3} mem_wr_state_e;
endpackage

// File: rtl/mem_byte_array.sv
// mem_byte_array: flop-based byte array, one synchronous write port, one combinational read port.
module mem_byte_array #(
   parameter int ADDR_W = 8,
   parameter int BYTE_W = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [BYTE_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [BYTE_W-1:0] rdata
);
   logic [BYTE_W-1:0] mem [2**ADDR_W];
   always_ff @(posedge clk) begin
      if (!rstn) mem <= '{default: '0};
      else if (we) mem[waddr] <= wdata;
   end
   assign rdata = mem[raddr];
endmodule

// File: rtl/mem_byte_store.sv
// mem_byte_store: byte memory that serialises 32-bit writes into 4-byte bursts with forwarded 1-cycle reads.
module mem_byte_store #(
   parameter int ADDR_W = mem_pkg::ADDR_W,
   parameter int DATA_W = mem_pkg::DATA_W,
   parameter int BYTE_W = mem_pkg::BYTE_W,
   parameter int CNT_W = mem_pkg::CNT_W
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] w_data,
   input  logic [ADDR_W-1:0] addr,
   input  logic              rd_en,
   output logic [BYTE_W-1:0] r_data,
   output logic              r_valid,
   output logic              busy,
   output logic [CNT_W-1:0]  drop_cnt
);
   import mem_pkg::*;
   mem_wr_state_e state, state_n;
   logic [BYTES_PER_WORD-1:0][BYTE_W-1:0] word_q, pend_word;
   logic [ADDR_W-1:0] base_q, pend_base, off, waddr;
   logic [1:0] idx;
   logic accept, we, fwd;
   logic [BYTE_W-1:0] wdata, mem_rdata, rd_val;
   assign busy = state != IDLE;
   // The word being written this cycle (fresh or captured) is the forwarding source for all 4 of its bytes.
   always_comb begin
      accept = !busy && wr_en;
      state_n = (busy || wr_en) ? mem_wr_state_e'(state + 2'd1) : IDLE;
      idx = state;
      pend_word = accept ? w_data : word_q;
      pend_base = accept ? addr : base_q;
      we = accept || busy;
      waddr = pend_base + ADDR_W'(idx);
      wdata = pend_word[idx];
      off = addr - pend_base;
      fwd = we && off < ADDR_W'(BYTES_PER_WORD);
      rd_val = fwd ? pend_word[off[1:0]] : mem_rdata;
   end
   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else state <= state_n;
   end
   always_ff @(posedge clk) begin
      if (!rstn) begin
         word_q <= '0;
         base_q <= '0;
      end else if (accept) begin
         word_q <= w_data;
         base_q <= addr;
      end
   end
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_data <= '0;
         r_valid <= 1'b0;
         drop_cnt <= '0;
      end else begin
         r_valid <= rd_en;
         if (rd_en) r_data <= rd_val;
         if (wr_en && busy && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
   end
   mem_byte_array #(.ADDR_W(ADDR_W), .BYTE_W(BYTE_W)) u_array (
      .clk(clk),
      .rstn(rstn),
      .we(we),
      .waddr(waddr),
      .wdata(wdata),
      .raddr(addr),
      .rdata(mem_rdata)
   );
endmodule
